// File: rtl/polyphase_interpolator_tdm.sv
// Runtime-rate polyphase interpolator built around one time-multiplexed MAC.
// Each input sample (and each tail-flush zero) yields rate_q outputs; every
// output is one SUB_LENGTH-tap dot product of the delay line with one phase
// of the prototype filter.
//
// state | meaning
// IDLE  | waiting for an input sample, data_in_tready=1
// MAC   | SUB_LENGTH product cycles plus pipeline drain into acc
// OUT   | result presented on data_out_*, held until handshake
// FLUSH | shift a zero into the delay line to push out the filter tail
module polyphase_interpolator_tdm #(
  parameter int NUMBER_TAPS       = 32,
  parameter int MAX_RATE          = 8,
  parameter int DATA_IN_WIDTH     = 16,
  parameter int DATA_OUT_WIDTH    = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int OUTPUT_SHIFT      = 15
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [$clog2(MAX_RATE):0]             rate,
  input  logic [DATA_IN_WIDTH-1:0]              data_in_tdata,
  input  logic                                  data_in_tvalid,
  input  logic                                  data_in_tlast,
  output logic                                  data_in_tready,
  output logic [DATA_OUT_WIDTH-1:0]             data_out_tdata,
  output logic                                  data_out_tvalid,
  output logic                                  data_out_tlast,
  input  logic                                  data_out_tready,
  input  logic                                  coeffs_wren,
  input  logic [$clog2(NUMBER_TAPS)-1:0]        coeffs_addr,
  input  logic [COEFFICIENT_WIDTH-1:0]          coeffs_wdata,
  output logic                                  busy
);

  localparam int SUB_LENGTH = NUMBER_TAPS / MAX_RATE;
  localparam int ACC_W      = DATA_IN_WIDTH + COEFFICIENT_WIDTH + $clog2(NUMBER_TAPS);
  localparam int PROD_W     = DATA_IN_WIDTH + COEFFICIENT_WIDTH;
  localparam int ADDR_W     = $clog2(NUMBER_TAPS);
  localparam int PH_W       = $clog2(MAX_RATE);
  localparam int RATE_W     = PH_W + 1;
  localparam int CNT_W      = $clog2(SUB_LENGTH + 2);
  localparam int TAP_W      = (SUB_LENGTH > 1) ? $clog2(SUB_LENGTH) : 1;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (OUTPUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_FLUSH} state_t;

  state_t                              state_q, state_d;
  logic signed [DATA_IN_WIDTH-1:0]     x_q [SUB_LENGTH];
  logic signed [DATA_IN_WIDTH-1:0]     x_d [SUB_LENGTH];
  logic signed [COEFFICIENT_WIDTH-1:0] coef_q [NUMBER_TAPS];
  logic signed [COEFFICIENT_WIDTH-1:0] coef_d [NUMBER_TAPS];
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic signed [PROD_W-1:0]            prod_q, prod_d;
  logic                                prod_v_q, prod_v_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [PH_W-1:0]                     phase_q, phase_d;
  logic [RATE_W-1:0]                   rate_q, rate_d;
  logic                                first_q, first_d;
  logic                                last_q, last_d;
  logic [CNT_W-1:0]                    flush_left_q, flush_left_d;

  logic [TAP_W-1:0]        tap_idx;
  logic [ADDR_W-1:0]       coef_addr;
  logic                    last_phase;
  logic [RATE_W-1:0]       rate_clamped;
  logic signed [ACC_W-1:0] rounded, shifted;
  logic [DATA_OUT_WIDTH-1:0] sat_out;

  // Coefficient store: write port only, deliberately untouched by reset.
  always_comb begin
    coef_d = coef_q;
    if (coeffs_wren) coef_d[coeffs_addr] = coeffs_wdata;
  end

  // Coefficient store register (no reset).
  always_ff @(posedge aclk) begin
    coef_q <= coef_d;
  end

  // Tap/phase address decode, rate clamping and phase-end detect.
  always_comb begin
    tap_idx   = cnt_q[TAP_W-1:0];
    coef_addr = ADDR_W'(int'(cnt_q) * MAX_RATE + int'(phase_q));
    last_phase = (RATE_W'(phase_q) == (rate_q - RATE_W'(1)));
    if (rate == '0)                         rate_clamped = RATE_W'(1);
    else if (rate > RATE_W'(MAX_RATE))      rate_clamped = RATE_W'(MAX_RATE);
    else                                    rate_clamped = rate;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    acc_d        = acc_q;
    prod_d       = prod_q;
    prod_v_d     = 1'b0;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    rate_d       = rate_q;
    first_d      = first_q;
    last_d       = last_q;
    flush_left_d = flush_left_q;
    case (state_q)
      S_IDLE: begin
        if (data_in_tvalid) begin
          x_d[0] = data_in_tdata;
          for (int k = 1; k < SUB_LENGTH; k++) x_d[k] = x_q[k-1];
          phase_d = '0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
          if (first_q) begin
            rate_d  = rate_clamped;
            first_d = 1'b0;
          end
          if (data_in_tlast) begin
            last_d       = 1'b1;
            flush_left_d = CNT_W'(SUB_LENGTH - 1);
          end
        end
      end
      S_MAC: begin
        // One registered product stage: acc trails the product by a cycle,
        // so the count runs two past the last tap before the result is final.
        if (prod_v_q) acc_d = acc_q + ACC_W'(prod_q);
        if (cnt_q < CNT_W'(SUB_LENGTH)) begin
          prod_d   = x_q[tap_idx] * coef_q[coef_addr];
          prod_v_d = 1'b1;
        end
        if (cnt_q == CNT_W'(SUB_LENGTH + 1)) state_d = S_OUT;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      S_OUT: begin
        if (data_out_tready) begin
          if (!last_phase) begin
            phase_d = phase_q + PH_W'(1);
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end else if (last_q && (flush_left_q != '0)) begin
            flush_left_d = flush_left_q - CNT_W'(1);
            state_d      = S_FLUSH;
          end else begin
            state_d = S_IDLE;
            if (last_q) begin
              for (int k = 0; k < SUB_LENGTH; k++) x_d[k] = '0;
              last_d  = 1'b0;
              first_d = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        x_d[0] = '0;
        for (int k = 1; k < SUB_LENGTH; k++) x_d[k] = x_q[k-1];
        phase_d = '0;
        cnt_d   = '0;
        acc_d   = '0;
        state_d = S_MAC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      for (int k = 0; k < SUB_LENGTH; k++) x_q[k] <= '0;
      acc_q        <= '0;
      prod_q       <= '0;
      prod_v_q     <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= '0;
      rate_q       <= RATE_W'(1);
      first_q      <= 1'b1;
      last_q       <= 1'b0;
      flush_left_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      prod_v_q     <= prod_v_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      rate_q       <= rate_d;
      first_q      <= first_d;
      last_q       <= last_d;
      flush_left_q <= flush_left_d;
    end
  end

  // Round half-up, arithmetic shift, saturate to the output width.
  always_comb begin
    rounded = acc_q + RND;
    shifted = rounded >>> OUTPUT_SHIFT;
    if (shifted > OUT_MAX)      sat_out = OUT_MAX[DATA_OUT_WIDTH-1:0];
    else if (shifted < OUT_MIN) sat_out = OUT_MIN[DATA_OUT_WIDTH-1:0];
    else                        sat_out = shifted[DATA_OUT_WIDTH-1:0];
  end

  assign data_in_tready  = (state_q == S_IDLE);
  assign data_out_tvalid = (state_q == S_OUT);
  assign data_out_tdata  = sat_out;
  assign data_out_tlast  = (state_q == S_OUT) && last_q && (flush_left_q == '0) && last_phase;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_polyphase_interpolator_tdm.sv
// Directed bench for polyphase_interpolator_tdm: a table of frames with
// hand-computed outputs, plus latency, backpressure and mid-frame reset.
module tb_polyphase_interpolator_tdm;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  rate = 4'd1;
  logic [15:0] data_in_tdata = '0;
  logic        data_in_tvalid = 1'b0;
  logic        data_in_tlast = 1'b0;
  logic        data_in_tready;
  logic [15:0] data_out_tdata;
  logic        data_out_tvalid;
  logic        data_out_tlast;
  logic        data_out_tready = 1'b1;
  logic        coeffs_wren = 1'b0;
  logic [4:0]  coeffs_addr = '0;
  logic [15:0] coeffs_wdata = '0;
  logic        busy;

  polyphase_interpolator_tdm dut (
    .aclk(aclk), .aresetn(aresetn), .rate(rate),
    .data_in_tdata(data_in_tdata), .data_in_tvalid(data_in_tvalid),
    .data_in_tlast(data_in_tlast), .data_in_tready(data_in_tready),
    .data_out_tdata(data_out_tdata), .data_out_tvalid(data_out_tvalid),
    .data_out_tlast(data_out_tlast), .data_out_tready(data_out_tready),
    .coeffs_wren(coeffs_wren), .coeffs_addr(coeffs_addr),
    .coeffs_wdata(coeffs_wdata), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int          rate_first;
    int          rate_later;
    int          nin;
    logic [15:0] x [4];
    bit          hsat;
    bit          rnd_ready;
    int          nout;
    logic [15:0] exp_out [32];
  } vec_t;

  localparam int NCASE = 6;
  vec_t cases [NCASE];

  int n_pass = 0;
  int n_total = 0;
  int hs_cyc;
  int cur_hmode = -1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
  endtask

  task automatic load_coeffs(input bit hsat);
    if (cur_hmode != int'(hsat)) begin
      for (int n = 0; n < 32; n++) begin
        @(negedge aclk);
        coeffs_wren  = 1'b1;
        coeffs_addr  = 5'(n);
        coeffs_wdata = hsat ? 16'h7FFF : 16'(2 * (n + 1));
      end
      @(negedge aclk);
      coeffs_wren = 1'b0;
      cur_hmode = int'(hsat);
    end
  endtask

  task automatic drive_inputs(input int ci);
    int w;
    for (int s = 0; s < cases[ci].nin; s++) begin
      @(negedge aclk);
      rate           = 4'((s == 0) ? cases[ci].rate_first : cases[ci].rate_later);
      data_in_tdata  = cases[ci].x[s];
      data_in_tlast  = (s == cases[ci].nin - 1);
      data_in_tvalid = 1'b1;
      w = 0;
      while (!data_in_tready && w < 2000) begin
        @(negedge aclk);
        w++;
      end
      if (w >= 2000) begin
        chk("in_handshake_timeout", 0, 1);
        data_in_tvalid = 1'b0;
        return;
      end
      @(negedge aclk);
      if (s == 0) hs_cyc = cyc;
      data_in_tvalid = 1'b0;
      data_in_tlast  = 1'b0;
      chk("in_tready_low_while_busy", int'(data_in_tready), 0);
    end
  endtask

  task automatic collect_outputs(input int ci);
    int          idx = 0;
    int          budget = 0;
    bit          seen_first = 1'b0;
    bit          seen_last = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    while (!seen_last && budget < 3000) begin
      @(negedge aclk);
      budget++;
      data_out_tready = cases[ci].rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if (data_out_tvalid) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          chk($sformatf("case%0d_latency", ci), cyc - hs_cyc, 6);
        end
        if (stalled) begin
          chk($sformatf("case%0d_stall_data", ci), int'(data_out_tdata), int'(prev_data));
          chk($sformatf("case%0d_stall_tlast", ci), int'(data_out_tlast), int'(prev_last));
        end
        if (data_out_tready) begin
          if (idx < cases[ci].nout) begin
            chk($sformatf("case%0d_out%0d", ci, idx), int'(data_out_tdata), int'(cases[ci].exp_out[idx]));
            chk($sformatf("case%0d_tlast%0d", ci, idx), int'(data_out_tlast), int'(idx == cases[ci].nout - 1));
          end
          idx++;
          if (data_out_tlast) seen_last = 1'b1;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
        prev_data = data_out_tdata;
        prev_last = data_out_tlast;
      end else begin
        stalled = 1'b0;
      end
    end
    if (!seen_last) chk($sformatf("case%0d_out_timeout", ci), 0, 1);
    chk($sformatf("case%0d_out_count", ci), idx, cases[ci].nout);
    data_out_tready = 1'b1;
  endtask

  task automatic run_case(input int ci);
    load_coeffs(cases[ci].hsat);
    fork
      drive_inputs(ci);
      collect_outputs(ci);
    join
    repeat (2) @(negedge aclk);
    chk($sformatf("case%0d_idle_after", ci), int'(busy), 0);
  endtask

  initial begin
    // T1: impulse at rate 8 -> 1..32
    cases[0].rate_first = 8; cases[0].rate_later = 8; cases[0].nin = 1;
    cases[0].x = '{16'h4000, 16'h0, 16'h0, 16'h0};
    cases[0].hsat = 1'b0; cases[0].rnd_ready = 1'b0; cases[0].nout = 32;
    for (int k = 0; k < 32; k++) cases[0].exp_out[k] = 16'(k + 1);
    // T2: rate 2, three inputs; rate change after the first must be ignored
    cases[1].rate_first = 2; cases[1].rate_later = 8; cases[1].nin = 3;
    cases[1].x = '{16'h4000, 16'h0, 16'h0, 16'h0};
    cases[1].hsat = 1'b0; cases[1].rnd_ready = 1'b0; cases[1].nout = 12;
    cases[1].exp_out = '{default: 16'h0};
    for (int k = 0; k < 4; k++) begin
      cases[1].exp_out[2*k]     = 16'(8*k + 1);
      cases[1].exp_out[2*k + 1] = 16'(8*k + 2);
    end
    // rate 0 clamps to 1: phase 0 of each step only
    cases[2].rate_first = 0; cases[2].rate_later = 0; cases[2].nin = 1;
    cases[2].x = '{16'h4000, 16'h0, 16'h0, 16'h0};
    cases[2].hsat = 1'b0; cases[2].rnd_ready = 1'b0; cases[2].nout = 4;
    cases[2].exp_out = '{default: 16'h0};
    for (int k = 0; k < 4; k++) cases[2].exp_out[k] = 16'(8*k + 1);
    // rate 15 clamps to 8, with random backpressure (T4)
    cases[3] = cases[0];
    cases[3].rate_first = 15; cases[3].rate_later = 15; cases[3].rnd_ready = 1'b1;
    // T3 positive saturation, rate 1
    cases[4].rate_first = 1; cases[4].rate_later = 1; cases[4].nin = 4;
    cases[4].x = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    cases[4].hsat = 1'b1; cases[4].rnd_ready = 1'b0; cases[4].nout = 7;
    cases[4].exp_out = '{default: 16'h7FFF};
    cases[4].exp_out[0] = 16'h7FFE; cases[4].exp_out[6] = 16'h7FFE;
    // T3 negative saturation
    cases[5] = cases[4];
    cases[5].x = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    cases[5].exp_out = '{default: 16'h8000};
    cases[5].exp_out[0] = 16'h8001; cases[5].exp_out[6] = 16'h8001;

    repeat (3) @(negedge aclk);
    chk("rst_out_tvalid", int'(data_out_tvalid), 0);
    chk("rst_in_tready", int'(data_in_tready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_tdata", int'(data_out_tdata), 0);
    chk("rst_out_tlast", int'(data_out_tlast), 0);
    aresetn = 1'b1;

    for (int ci = 0; ci < NCASE; ci++) run_case(ci);

    // T6: reset during MAC of an impulse frame, then rerun without rewriting coeffs
    load_coeffs(1'b0);
    @(negedge aclk);
    rate = 4'd8; data_in_tdata = 16'h4000; data_in_tlast = 1'b1; data_in_tvalid = 1'b1;
    @(negedge aclk);
    data_in_tvalid = 1'b0; data_in_tlast = 1'b0;
    repeat (2) @(negedge aclk);
    chk("t6_busy_in_mac", int'(busy), 1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_out_tvalid", int'(data_out_tvalid), 0);
    chk("t6_rst_in_tready", int'(data_in_tready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_out_tdata", int'(data_out_tdata), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    run_case(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
